// File: rtl/pbkdf2_req_loader_if.sv
// Request-loader bus: byte stream in, PBKDF2 request words out.
// Signal names keep the loader's point of view (_i into the loader, _o out of it).
interface pbkdf2_req_loader_if;
  logic [7:0]   data_i;
  logic         v_i;
  logic         r_o;
  logic [31:0]  iters_o;
  logic [511:0] pass_o;
  logic [511:0] salt_o;
  logic [5:0]   salt_len_o;
  logic         v_o;
  logic         r_i;
  logic         err_o;

  modport master (
    output data_i, v_i, r_i,
    input  r_o, iters_o, pass_o, salt_o, salt_len_o, v_o, err_o
  );

  modport slave (
    input  data_i, v_i, r_i,
    output r_o, iters_o, pass_o, salt_o, salt_len_o, v_o, err_o
  );
endinterface

// File: rtl/pbkdf2_req_loader.sv
// Parses a framed byte stream (iters, pass_len, salt_len, password, salt)
// into the parallel request words consumed by the PBKDF2 core.
module pbkdf2_req_loader (
  input  logic                 clk_i,
  input  logic                 rst_i,
  pbkdf2_req_loader_if.slave   bus
);

  typedef enum logic [2:0] {StHdr, StPass, StSalt, StOut, StErr} state_e;

  state_e       state_q, state_d;
  logic [2:0]   hdr_cnt_q, hdr_cnt_d;
  logic [6:0]   idx_q, idx_d;
  logic [7:0]   pass_len_q, pass_len_d;
  logic [31:0]  iters_q, iters_d;
  logic [511:0] pass_q, pass_d;
  logic [511:0] salt_q, salt_d;
  logic [5:0]   salt_len_q, salt_len_d;

  logic ready;
  logic accept;
  logic hdr_ok;
  logic last_pass;
  logic last_salt;

  assign accept    = bus.v_i & ready;
  // Evaluated on header byte 5, so data_i is the incoming salt_len.
  assign hdr_ok    = (pass_len_q != 8'd0) && (pass_len_q <= 8'd64) &&
                     (bus.data_i <= 8'd63) && (iters_q != 32'd0);
  assign last_pass = ({1'b0, idx_q} == (pass_len_q - 8'd1));
  assign last_salt = (idx_q[5:0] == (salt_len_q - 6'd1));

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StHdr;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StHdr: begin
        if (accept && (hdr_cnt_q == 3'd5)) begin
          state_d = hdr_ok ? StPass : StErr;
        end
      end
      StPass: begin
        if (accept && last_pass) begin
          state_d = (salt_len_q != 6'd0) ? StSalt : StOut;
        end
      end
      StSalt: begin
        if (accept && last_salt) begin
          state_d = StOut;
        end
      end
      StOut: begin
        if (bus.r_i) begin
          state_d = StHdr;
        end
      end
      StErr:   state_d = StHdr;
      default: state_d = StHdr;
    endcase
  end

  // Outputs decoded from state only
  always_comb begin
    ready     = (state_q == StHdr) || (state_q == StPass) || (state_q == StSalt);
    bus.r_o   = ready;
    bus.v_o   = (state_q == StOut);
    bus.err_o = (state_q == StErr);
  end

  // Datapath next-state
  always_comb begin
    hdr_cnt_d  = hdr_cnt_q;
    idx_d      = idx_q;
    pass_len_d = pass_len_q;
    iters_d    = iters_q;
    pass_d     = pass_q;
    salt_d     = salt_q;
    salt_len_d = salt_len_q;
    if (accept) begin
      unique case (state_q)
        StHdr: begin
          hdr_cnt_d = (hdr_cnt_q == 3'd5) ? 3'd0 : hdr_cnt_q + 3'd1;
          unique case (hdr_cnt_q)
            3'd0: begin
              pass_d     = '0;
              salt_d     = '0;
              salt_len_d = '0;
              iters_d    = {24'd0, bus.data_i};
            end
            3'd1, 3'd2, 3'd3: iters_d = {iters_q[23:0], bus.data_i};
            3'd4: pass_len_d = bus.data_i;
            3'd5: begin
              salt_len_d = bus.data_i[5:0];
              idx_d      = 7'd0;
            end
            default: ;
          endcase
        end
        StPass: begin
          // {~k, 3'b111} == 511 - 8k for a 6-bit byte index k.
          pass_d[{~idx_q[5:0], 3'b111} -: 8] = bus.data_i;
          idx_d = last_pass ? 7'd0 : idx_q + 7'd1;
        end
        StSalt: begin
          salt_d[{~idx_q[5:0], 3'b111} -: 8] = bus.data_i;
          idx_d = last_salt ? 7'd0 : idx_q + 7'd1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hdr_cnt_q  <= '0;
      idx_q      <= '0;
      pass_len_q <= '0;
      iters_q    <= '0;
      pass_q     <= '0;
      salt_q     <= '0;
      salt_len_q <= '0;
    end else begin
      hdr_cnt_q  <= hdr_cnt_d;
      idx_q      <= idx_d;
      pass_len_q <= pass_len_d;
      iters_q    <= iters_d;
      pass_q     <= pass_d;
      salt_q     <= salt_d;
      salt_len_q <= salt_len_d;
    end
  end

  assign bus.iters_o    = iters_q;
  assign bus.pass_o     = pass_q;
  assign bus.salt_o     = salt_q;
  assign bus.salt_len_o = salt_len_q;

endmodule

// File: tb/tb_pbkdf2_req_loader.sv
// Randomized bench for pbkdf2_req_loader against a frame-level reference model.
module tb_pbkdf2_req_loader;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  pbkdf2_req_loader_if bus ();

  pbkdf2_req_loader dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] frame[$];

  task automatic check_val(input string tag, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: interpret the whole frame at once.
  task automatic model(output bit good, output logic [31:0] it, output logic [511:0] p,
                       output logic [511:0] s, output logic [5:0] sl, output int nbytes);
    int plen;
    int slen;
    it   = {frame[0], frame[1], frame[2], frame[3]};
    plen = frame[4];
    slen = frame[5];
    good = (plen >= 1) && (plen <= 64) && (slen <= 63) && (it != 0);
    p  = '0;
    s  = '0;
    sl = slen[5:0];
    if (!good) begin
      nbytes = 6;
      return;
    end
    for (int k = 0; k < plen; k++) p = (p << 8) | 512'(frame[6 + k]);
    p = p << (8 * (64 - plen));
    for (int k = 0; k < slen; k++) s = (s << 8) | 512'(frame[6 + plen + k]);
    s = s << (8 * (64 - slen));
    nbytes = 6 + plen + slen;
  endtask

  task automatic build_frame(input logic [31:0] it, input int plen, input int slen);
    frame.delete();
    for (int b = 3; b >= 0; b--) frame.push_back(it[8*b +: 8]);
    frame.push_back(8'(plen));
    frame.push_back(8'(slen));
    for (int k = 0; k < plen + slen; k++) frame.push_back(8'($urandom));
  endtask

  // Returns at the negedge right after the last byte was accepted.
  task automatic send_bytes(input int n, input int vprob);
    int i;
    int cyc;
    bit pend;
    i = 0;
    cyc = 0;
    pend = 1'b0;
    while (i < n && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      if (pend) i++;
      pend = 1'b0;
      if (i < n && $urandom_range(99) < vprob) begin
        bus.v_i    = 1'b1;
        bus.data_i = frame[i];
        pend       = bus.r_o;
      end else begin
        bus.v_i    = 1'b0;
        bus.data_i = 8'($urandom);
      end
    end
    bus.v_i = 1'b0;
    if (i < n) check_val("send_timeout", 512'(i), 512'(n));
  endtask

  task automatic run_frame(input int vprob, input int stall);
    bit          good;
    logic [31:0] it;
    logic [511:0] p;
    logic [511:0] s;
    logic [5:0]  sl;
    int          n;
    model(good, it, p, s, sl, n);
    send_bytes(n, vprob);
    if (good) begin
      check_val("v_latency", 512'(bus.v_o), 512'(1));
      check_val("err_idle", 512'(bus.err_o), 512'(0));
      check_val("iters", 512'(bus.iters_o), 512'(it));
      check_val("pass", bus.pass_o, p);
      check_val("salt", bus.salt_o, s);
      check_val("salt_len", 512'(bus.salt_len_o), 512'(sl));
      for (int c = 0; c < stall; c++) begin
        bus.r_i    = 1'b0;
        bus.v_i    = 1'b1;
        bus.data_i = 8'($urandom);
        @(negedge clk);
        check_val("hold_v", 512'(bus.v_o), 512'(1));
        check_val("hold_r", 512'(bus.r_o), 512'(0));
        check_val("hold_pass", bus.pass_o, p);
        check_val("hold_salt", bus.salt_o, s);
        check_val("hold_iters", 512'(bus.iters_o), 512'(it));
      end
      bus.v_i = 1'b0;
      bus.r_i = 1'b1;
      @(negedge clk);
      bus.r_i = 1'b0;
      check_val("drain_v", 512'(bus.v_o), 512'(0));
      check_val("drain_r", 512'(bus.r_o), 512'(1));
    end else begin
      check_val("err_pulse", 512'(bus.err_o), 512'(1));
      check_val("err_no_v", 512'(bus.v_o), 512'(0));
      @(negedge clk);
      check_val("err_single", 512'(bus.err_o), 512'(0));
      check_val("err_no_v2", 512'(bus.v_o), 512'(0));
      check_val("err_ready", 512'(bus.r_o), 512'(1));
    end
  endtask

  task automatic load_ref_frame();
    logic [63:0] pw;
    logic [31:0] sa;
    pw = 64'h70617373776f7264;
    sa = 32'h73616c74;
    frame.delete();
    frame.push_back(8'h00);
    frame.push_back(8'h00);
    frame.push_back(8'h10);
    frame.push_back(8'h00);
    frame.push_back(8'd8);
    frame.push_back(8'd4);
    for (int b = 7; b >= 0; b--) frame.push_back(pw[8*b +: 8]);
    for (int b = 3; b >= 0; b--) frame.push_back(sa[8*b +: 8]);
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    rst        = 1'b1;
    bus.v_i    = 1'b0;
    bus.r_i    = 1'b0;
    bus.data_i = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_val("rst_r", 512'(bus.r_o), 512'(1));
    check_val("rst_v", 512'(bus.v_o), 512'(0));
    check_val("rst_err", 512'(bus.err_o), 512'(0));
    check_val("rst_iters", 512'(bus.iters_o), 512'(0));
    check_val("rst_pass", bus.pass_o, 512'(0));
    check_val("rst_salt", bus.salt_o, 512'(0));
    check_val("rst_slen", 512'(bus.salt_len_o), 512'(0));

    // Reference frame, fixed-value sanity on top of the model
    load_ref_frame();
    send_bytes(18, 100);
    check_val("ref_v", 512'(bus.v_o), 512'(1));
    check_val("ref_pass", 512'(bus.pass_o[511:448]), 512'(64'h70617373776f7264));
    check_val("ref_salt", 512'(bus.salt_o[511:480]), 512'(32'h73616c74));
    check_val("ref_iters", 512'(bus.iters_o), 512'(4096));
    bus.r_i = 1'b1;
    @(negedge clk);
    bus.r_i = 1'b0;

    load_ref_frame();
    run_frame(100, 10);
    load_ref_frame();
    run_frame(50, 2);

    build_frame(32'd7, 64, 0);
    run_frame(100, 1);

    build_frame(32'd100, 0, 3);
    run_frame(100, 0);
    build_frame(32'd100, 65, 3);
    run_frame(100, 0);
    build_frame(32'd0, 8, 3);
    run_frame(100, 0);
    build_frame(32'd5, 8, 64);
    run_frame(70, 0);
    load_ref_frame();
    run_frame(100, 0);

    // Reset after 7 bytes discards the frame
    load_ref_frame();
    send_bytes(7, 100);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      check_val("rst_mid_v", 512'(bus.v_o), 512'(0));
      check_val("rst_mid_err", 512'(bus.err_o), 512'(0));
    end
    check_val("rst_mid_r", 512'(bus.r_o), 512'(1));
    check_val("rst_mid_pass", bus.pass_o, 512'(0));
    load_ref_frame();
    run_frame(100, 0);

    for (int f = 0; f < 30; f++) begin
      int kind;
      kind = int'($urandom_range(9));
      if (kind == 0)      build_frame(32'd0, int'($urandom_range(1, 64)), 2);
      else if (kind == 1) build_frame($urandom | 32'd1, int'($urandom_range(65, 255)), 1);
      else build_frame((kind == 2) ? 32'd1 : ($urandom | 32'h100),
                       int'($urandom_range(1, 64)), int'($urandom_range(0, 63)));
      run_frame(int'($urandom_range(30, 100)), int'($urandom_range(0, 4)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
